tb_ram_arbiter: RTL and testbench

- Shares one single-port synchronous testbench RAM between the core's instruction-fetch port and data port.
- Sits inside the core wrapper, between the core's OBI-style instr/data interfaces and the RAM macro; replaces the dual-port RAM for single-port memory bring-up.
- Provides round-robin or data-priority arbitration with starvation aging, one-cycle read response and a saturating conflict counter.

---
 rtl/tb_ram_arbiter.sv | 174 +++++++++++++++++
 tb/tb_tb_ram_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/tb_ram_arbiter.sv
// tb_ram_arbiter
// Shares one single-port synchronous RAM between the instruction-fetch
// port and the data port of the core. Only one port is granted per cycle.
// The granted access drives the RAM in that same cycle, and its response
// is returned one cycle later.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   instr_*_i/_o      OBI-style instruction port (read only)
//   data_*_i/_o       OBI-style data port (read/write, byte enables)
//   mem_*_o, mem_rdata_i
//                     single-port RAM macro interface (word addressed,
//                     read data valid the cycle after mem_en_o)
//   conflict_cnt_o    saturating count of cycles where both ports requested
//
// PRIORITY_MODE 0 selects round-robin arbitration.
// PRIORITY_MODE 1 gives the data port fixed priority. The instruction port
// is forced to win once it has been refused MAX_STARVE cycles in a row.
module tb_ram_arbiter #(
  parameter int unsigned ADDR_WIDTH    = 22,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned PRIORITY_MODE = 0,
  parameter int unsigned MAX_STARVE    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    instr_req_i,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    mem_en_o,
  output logic [ADDR_WIDTH-3:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic [31:0]             conflict_cnt_o
);

  localparam logic [3:0] STARVE_LIMIT = 4'(MAX_STARVE);

  typedef enum logic {
    LAST_INSTR,
    LAST_DATA
  } last_grant_e;

  // Data writes get their own owner state so that the response phase can
  // force data_rdata_o to zero for writes.
  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_INSTR,
    RESP_DATA_RD,
    RESP_DATA_WR
  } resp_owner_e;

  last_grant_e  last_grant_q, last_grant_d;
  resp_owner_e  resp_owner_q, resp_owner_d;
  logic [3:0]   starve_cnt_q, starve_cnt_d;
  logic [31:0]  conflict_cnt_q, conflict_cnt_d;

  logic         both_req;
  logic         instr_gnt;
  logic         data_gnt;

  // Byte-offset bits are ignored because the RAM is word addressed.
  logic         unused_addr_lsbs;
  assign unused_addr_lsbs = ^{instr_addr_i[1:0], data_addr_i[1:0]};

  assign both_req = instr_req_i && data_req_i;

  // Arbitration. A lone requester always wins. On a conflict, the winner
  // is chosen by the selected policy.
  always_comb begin
    instr_gnt = 1'b0;
    data_gnt  = 1'b0;
    if (both_req) begin
      if (PRIORITY_MODE == 0) begin
        instr_gnt = (last_grant_q == LAST_DATA);
      end else begin
        instr_gnt = (starve_cnt_q == STARVE_LIMIT);
      end
      data_gnt = !instr_gnt;
    end else begin
      instr_gnt = instr_req_i;
      data_gnt  = data_req_i;
    end
  end

  // Drive the RAM with the winner's payload.
  // The RAM interface is held at zero when no port is granted.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (instr_gnt) begin
      mem_en_o   = 1'b1;
      mem_addr_o = instr_addr_i[ADDR_WIDTH-1:2];
      mem_be_o   = '1;
    end else if (data_gnt) begin
      mem_en_o    = 1'b1;
      mem_addr_o  = data_addr_i[ADDR_WIDTH-1:2];
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_wdata_o = data_wdata_i;
    end
  end

  // Next-state logic for the arbitration history, the starvation aging,
  // the pending-response owner and the conflict statistics.
  always_comb begin
    last_grant_d   = last_grant_q;
    starve_cnt_d   = starve_cnt_q;
    resp_owner_d   = RESP_NONE;
    conflict_cnt_d = conflict_cnt_q;

    if (instr_gnt) begin
      last_grant_d = LAST_INSTR;
      resp_owner_d = RESP_INSTR;
    end else if (data_gnt) begin
      last_grant_d = LAST_DATA;
      resp_owner_d = data_we_i ? RESP_DATA_WR : RESP_DATA_RD;
    end

    if (instr_gnt) begin
      starve_cnt_d = '0;
    end else if (instr_req_i && (starve_cnt_q != STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    if (both_req && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 32'd1;
    end
  end

  // State registers. On reset, last_grant is DATA so that the first
  // round-robin conflict goes to the instruction port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q   <= LAST_DATA;
      resp_owner_q   <= RESP_NONE;
      starve_cnt_q   <= '0;
      conflict_cnt_q <= '0;
    end else begin
      last_grant_q   <= last_grant_d;
      resp_owner_q   <= resp_owner_d;
      starve_cnt_q   <= starve_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign instr_gnt_o    = instr_gnt;
  assign data_gnt_o     = data_gnt;

  // Response phase. RAM read data is routed to whichever port owned the
  // previous cycle's access. The other port sees zero.
  assign instr_rvalid_o = (resp_owner_q == RESP_INSTR);
  assign instr_rdata_o  = (resp_owner_q == RESP_INSTR) ? mem_rdata_i : '0;
  assign data_rvalid_o  = (resp_owner_q == RESP_DATA_RD) || (resp_owner_q == RESP_DATA_WR);
  assign data_rdata_o   = (resp_owner_q == RESP_DATA_RD) ? mem_rdata_i : '0;

  assign conflict_cnt_o = conflict_cnt_q;

endmodule

// File: tb/tb_tb_ram_arbiter.sv
// tb_tb_ram_arbiter
// Directed bench for tb_ram_arbiter. It drives two instances in parallel:
// dut0 uses round-robin arbitration, and dut1 uses data priority with
// MAX_STARVE=4. Inputs change on the falling edge. Outputs are sampled
// 1 ns later for grants and 1 ns after the rising edge for responses.
module tb_tb_ram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        instr_req;
  logic [21:0] instr_addr;
  logic        data_req;
  logic [21:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;

  logic        i_gnt0, i_rvalid0, d_gnt0, d_rvalid0, m_en0, m_we0;
  logic [31:0] i_rdata0, d_rdata0, m_wdata0, m_rdata0, cnt0;
  logic [19:0] m_addr0;
  logic [3:0]  m_be0;

  logic        i_gnt1, i_rvalid1, d_gnt1, d_rvalid1, m_en1, m_we1;
  logic [31:0] i_rdata1, d_rdata1, m_wdata1, m_rdata1, cnt1;
  logic [19:0] m_addr1;
  logic [3:0]  m_be1;

  logic [31:0] ram [0:2047];

  int checks;
  int errors;

  tb_ram_arbiter #(.PRIORITY_MODE(0), .MAX_STARVE(4)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr),
    .instr_gnt_o(i_gnt0), .instr_rvalid_o(i_rvalid0), .instr_rdata_o(i_rdata0),
    .data_req_i(data_req), .data_addr_i(data_addr), .data_we_i(data_we),
    .data_be_i(data_be), .data_wdata_i(data_wdata),
    .data_gnt_o(d_gnt0), .data_rvalid_o(d_rvalid0), .data_rdata_o(d_rdata0),
    .mem_en_o(m_en0), .mem_addr_o(m_addr0), .mem_we_o(m_we0), .mem_be_o(m_be0),
    .mem_wdata_o(m_wdata0), .mem_rdata_i(m_rdata0), .conflict_cnt_o(cnt0)
  );

  tb_ram_arbiter #(.PRIORITY_MODE(1), .MAX_STARVE(4)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr),
    .instr_gnt_o(i_gnt1), .instr_rvalid_o(i_rvalid1), .instr_rdata_o(i_rdata1),
    .data_req_i(data_req), .data_addr_i(data_addr), .data_we_i(data_we),
    .data_be_i(data_be), .data_wdata_i(data_wdata),
    .data_gnt_o(d_gnt1), .data_rvalid_o(d_rvalid1), .data_rdata_o(d_rdata1),
    .mem_en_o(m_en1), .mem_addr_o(m_addr1), .mem_we_o(m_we1), .mem_be_o(m_be1),
    .mem_wdata_o(m_wdata1), .mem_rdata_i(m_rdata1), .conflict_cnt_o(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM behind dut0, with one cycle of read latency.
  always @(posedge clk) begin
    if (m_en0) begin
      if (m_we0) begin
        for (int b = 0; b < 4; b++) begin
          if (m_be0[b]) ram[m_addr0[10:0]][8*b +: 8] <= m_wdata0[8*b +: 8];
        end
      end else begin
        m_rdata0 <= ram[m_addr0[10:0]];
      end
    end
  end

  // dut1 only needs recognisable read data, so it returns its word index.
  always @(posedge clk) begin
    if (m_en1) m_rdata1 <= {12'h000, m_addr1};
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ireq, input logic [21:0] iaddr,
                               input logic dreq, input logic [21:0] daddr,
                               input logic we, input logic [3:0] be,
                               input logic [31:0] wdata);
    @(negedge clk);
    instr_req  = ireq;
    instr_addr = iaddr;
    data_req   = dreq;
    data_addr  = daddr;
    data_we    = we;
    data_be    = be;
    data_wdata = wdata;
    #1;
  endtask

  task automatic afterEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst_n = 1'b0;
    instr_req = 1'b0;
    data_req  = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic exp_i;
    string pattern;
    checks = 0;
    errors = 0;
    m_rdata0 = '0;
    m_rdata1 = '0;
    for (int k = 0; k < 2048; k++) ram[k] = 32'h0;
    ram[11'h020] = 32'h0000_0013;
    ram[11'h401] = 32'h1122_3344;
    rst_n = 1'b0;
    instr_req = 1'b0; instr_addr = '0;
    data_req = 1'b0; data_addr = '0; data_we = 1'b0; data_be = '0; data_wdata = '0;
    #1;

    // Reset state.
    checkOutput("rst_instr_gnt", {31'b0, i_gnt0}, 32'h0);
    checkOutput("rst_data_gnt", {31'b0, d_gnt0}, 32'h0);
    checkOutput("rst_instr_rvalid", {31'b0, i_rvalid0}, 32'h0);
    checkOutput("rst_data_rvalid", {31'b0, d_rvalid0}, 32'h0);
    checkOutput("rst_mem_en", {31'b0, m_en0}, 32'h0);
    checkOutput("rst_conflict_cnt", cnt0, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;

    // Instruction-only read of byte address 0x80, which is word 0x20.
    applyStimulus(1'b1, 22'h80, 1'b0, 22'h0, 1'b0, 4'h0, 32'h0);
    checkOutput("ifetch_instr_gnt", {31'b0, i_gnt0}, 32'h1);
    checkOutput("ifetch_data_gnt", {31'b0, d_gnt0}, 32'h0);
    checkOutput("ifetch_mem_addr", {12'h0, m_addr0}, 32'h20);
    checkOutput("ifetch_mem_we", {31'b0, m_we0}, 32'h0);
    checkOutput("ifetch_mem_be", {28'h0, m_be0}, 32'hF);
    afterEdge();
    checkOutput("ifetch_rvalid", {31'b0, i_rvalid0}, 32'h1);
    checkOutput("ifetch_rdata", i_rdata0, 32'h0000_0013);
    checkOutput("ifetch_data_rvalid", {31'b0, d_rvalid0}, 32'h0);

    // Data write to 0x1004 with the low halfword enabled.
    applyStimulus(1'b0, 22'h0, 1'b1, 22'h1004, 1'b1, 4'b0011, 32'hAABB_CCDD);
    checkOutput("wr_data_gnt", {31'b0, d_gnt0}, 32'h1);
    checkOutput("wr_mem_we", {31'b0, m_we0}, 32'h1);
    checkOutput("wr_mem_addr", {12'h0, m_addr0}, 32'h401);
    checkOutput("wr_mem_be", {28'h0, m_be0}, 32'h3);
    checkOutput("wr_mem_wdata", m_wdata0, 32'hAABB_CCDD);
    afterEdge();
    checkOutput("wr_rvalid", {31'b0, d_rvalid0}, 32'h1);
    checkOutput("wr_rdata_zero", d_rdata0, 32'h0);

    // Read back the word. The high half was preserved and the low half was written.
    applyStimulus(1'b0, 22'h0, 1'b1, 22'h1004, 1'b0, 4'hF, 32'h0);
    checkOutput("rd_mem_we", {31'b0, m_we0}, 32'h0);
    afterEdge();
    checkOutput("rd_rvalid", {31'b0, d_rvalid0}, 32'h1);
    checkOutput("rd_rdata", d_rdata0, 32'h1122_CCDD);

    // Round-robin conflict for 6 cycles, starting from reset.
    pulseReset();
    for (int i = 0; i < 6; i++) begin
      exp_i = (i % 2 == 0);
      applyStimulus(1'b1, 22'h80, 1'b1, 22'h1004, 1'b0, 4'hF, 32'h0);
      checkOutput($sformatf("rr_instr_gnt_%0d", i), {31'b0, i_gnt0}, {31'b0, exp_i});
      checkOutput($sformatf("rr_data_gnt_%0d", i), {31'b0, d_gnt0}, {31'b0, !exp_i});
      afterEdge();
      checkOutput($sformatf("rr_instr_rvalid_%0d", i), {31'b0, i_rvalid0}, {31'b0, exp_i});
      checkOutput($sformatf("rr_data_rvalid_%0d", i), {31'b0, d_rvalid0}, {31'b0, !exp_i});
      if (exp_i) checkOutput($sformatf("rr_instr_rdata_%0d", i), i_rdata0, 32'h0000_0013);
      else       checkOutput($sformatf("rr_data_rdata_%0d", i), d_rdata0, 32'h1122_CCDD);
    end
    applyStimulus(1'b0, 22'h0, 1'b0, 22'h0, 1'b0, 4'h0, 32'h0);
    checkOutput("rr_conflict_cnt", cnt0, 32'd6);

    // Data priority with aging on dut1. The instruction port wins every fifth cycle.
    pulseReset();
    pattern = "DDDDIDDDDI";
    for (int i = 0; i < 10; i++) begin
      exp_i = (pattern[i] == "I");
      applyStimulus(1'b1, 22'h80, 1'b1, 22'h1004, 1'b0, 4'hF, 32'h0);
      checkOutput($sformatf("pri_instr_gnt_%0d", i), {31'b0, i_gnt1}, {31'b0, exp_i});
      checkOutput($sformatf("pri_data_gnt_%0d", i), {31'b0, d_gnt1}, {31'b0, !exp_i});
      afterEdge();
      checkOutput($sformatf("pri_instr_rvalid_%0d", i), {31'b0, i_rvalid1}, {31'b0, exp_i});
    end
    applyStimulus(1'b0, 22'h0, 1'b0, 22'h0, 1'b0, 4'h0, 32'h0);

    // Reset asserted while a data read response is pending.
    applyStimulus(1'b0, 22'h0, 1'b1, 22'h1004, 1'b0, 4'hF, 32'h0);
    checkOutput("midrst_data_gnt", {31'b0, d_gnt0}, 32'h1);
    @(posedge clk);
    rst_n = 1'b0;
    instr_req = 1'b0;
    data_req  = 1'b0;
    #1;
    checkOutput("midrst_data_rvalid", {31'b0, d_rvalid0}, 32'h0);
    checkOutput("midrst_data_rdata", d_rdata0, 32'h0);
    checkOutput("midrst_instr_rvalid", {31'b0, i_rvalid0}, 32'h0);
    checkOutput("midrst_mem_en", {31'b0, m_en0}, 32'h0);
    checkOutput("midrst_conflict_cnt", cnt0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    afterEdge();
    checkOutput("postrst_data_rvalid", {31'b0, d_rvalid0}, 32'h0);
    applyStimulus(1'b1, 22'h80, 1'b1, 22'h1004, 1'b0, 4'hF, 32'h0);
    checkOutput("postrst_instr_gnt", {31'b0, i_gnt0}, 32'h1);
    checkOutput("postrst_data_gnt", {31'b0, d_gnt0}, 32'h0);

    // Saturation of the conflict counter, starting one below the maximum.
    applyStimulus(1'b0, 22'h0, 1'b0, 22'h0, 1'b0, 4'h0, 32'h0);
    force dut0.conflict_cnt_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut0.conflict_cnt_q;
    #1;
    checkOutput("sat_preload", cnt0, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 22'h80, 1'b1, 22'h1004, 1'b0, 4'hF, 32'h0);
      afterEdge();
      checkOutput($sformatf("sat_cnt_%0d", i), cnt0, 32'hFFFF_FFFF);
    end
    applyStimulus(1'b0, 22'h0, 1'b0, 22'h0, 1'b0, 4'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
